wave_display: RTL
=================

# wave_display

Consumer stage for the double-buffered sample RAM filled by `wave_capture`. It converts the VGA raster position into RAM read addresses and renders the stored 8-bit samples as a connected trace in a 512×512 plot window. It latches the buffer index at frame start so the buffer never switches mid-frame. It asserts `wave_display_idle` while the raster is outside the plot, which is when capture may swap buffers. It sits between the sample RAM read port and the VGA colour mux.

## Interface
- `X_START`, 256: first plot column (inclusive)
- `X_END`, 767: last plot column (inclusive); 512 columns = 256 samples × 2 px
- `PLOT_ROWS`, 512: plot height from y=0; 2 rows per sample level
- `TRACE_RGB`, 24'hFFFFFF: trace colour
- `BG_RGB`, 24'h000000: colour for plot background and out-of-plot pixels
- `clk`  in  1  system clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `x`  in  11  raster column
- `y`  in  10  raster row
- `valid`  in  1  raster position is in the visible area
- `read_index`  in  1  buffer currently published by capture
- `read_address`  out  9  {latched_index, sample_idx[7:0]}, registered
- `read_value`  in  8  RAM data; synchronous read, valid 1 cycle after `read_address`
- `valid_pixel`  out  1  `valid` delayed 3 cycles
- `r`, `g`, `b`  out  8 each  pixel colour, registered
- `wave_display_idle`  out  1  high in the IDLE state

## Operation
- FSM has two states.
  - IDLE: `wave_display_idle`=1.
  - ACTIVE: `wave_display_idle`=0.
- IDLE→ACTIVE on `valid && x==0 && y==0`. On this edge, `latched_index <= read_index`.
- ACTIVE→IDLE on `valid && y==PLOT_ROWS`.
- `read_index` changes in ACTIVE are ignored until the next frame start.
- Sample index: `sidx = (x - X_START)[8:1]`, computed only when X_START ≤ x ≤ X_END. Outside that range, `read_address` holds its last value.
- Plot level: `lvl = 8'd255 - read_value`, so larger samples are drawn higher.
- `prev_lvl`:
  - Updated when a new sample is consumed, i.e. when stage-2 `sidx` ≠ the previous stage-2 `sidx`.
  - Marked invalid at the first plot column (x==X_START) of each row.
- Draw condition for an in-plot pixel:
  - Compare `y[8:1]` against min(prev_lvl, lvl) and max(prev_lvl, lvl), inclusive.
  - If `prev_lvl` is invalid, draw only where `y[8:1]==lvl`.
- Colour selection:
  - Pixel drawn → TRACE_RGB.
  - Otherwise (in plot, not drawn, or out of plot) → BG_RGB.
  - Delayed `valid`=0 → r=g=b=0.
- Reset values: state IDLE, `wave_display_idle`=1, `latched_index`=0, `read_address`=0, `valid_pixel`=0, r=g=b=0, `prev_lvl` invalid, pipeline valids 0.

## Timing
- Pipeline:
  - Cycle n: x/y/valid presented.
  - Edge n+1: `read_address` registered; x/y/valid captured into stage 1.
  - Cycle n+2: `read_value` valid (stage 2).
  - Edge n+3: r/g/b and `valid_pixel` registered.
- Total latency 3 cycles. Upstream supplies one raster position per cycle with no stall.
- `wave_display_idle` is registered from the FSM and changes 1 cycle after the triggering raster position.
- Reset mid-frame: outputs go to reset values immediately. No drawing occurs until the next x=0,y=0.
- Column wrap: x=X_END+1 is out of plot. On the next row, x=X_START restarts with `prev_lvl` invalid, so no stale span carries across rows.
- Simultaneous events:
  - `read_index` toggling on the frame-start cycle: the new value is latched.
  - Frame start while `valid`=0: ignored.

## Structure
- Shared package/header holds:
  - Plot constants (X_START, X_END, PLOT_ROWS).
  - FSM state encodings (IDLE, ACTIVE).
  - Pipeline depth constant (3).
- One sub-module, `wave_span_check`: combinational. Inputs `prev_lvl`, `prev_valid`, `lvl`, `row[7:0]`. Output `draw`. It isolates the min/max span compare.

## Test plan
- Hold reset=0 at x=300,y=10,valid=1 → `wave_display_idle`=1, `read_address`=0, r=g=b=0, `valid_pixel`=0. Release → outputs stay 0 until the frame start.
- Frame start with read_index=1 (x=0,y=0) → idle=0 one cycle later. At x=256, `read_address`=9'h100 after 1 edge. Toggle read_index to 0 mid-frame → address MSB stays 1 until the next frame.
- RAM model: addr 0 →128, addr 1 →130, so lvl 127 then 125.
  - Row y=254: pixels x=256,257 are TRACE_RGB.
  - Rows y=250..255 at x=258: TRACE_RGB.
  - Row y=248 at x=258: BG_RGB.
  - Outputs appear 3 cycles after the input.
- Raster reaches y=512 → `wave_display_idle`=1 next cycle. Change read_index to 0, then frame start → subsequent addresses have MSB 0.
- x=100, y=20, valid=1 → BG_RGB and `valid_pixel`=1 three cycles later. valid=0 → r=g=b=0 and `valid_pixel`=0.
- Row end: x=768 → BG_RGB. Next row x=256 with addr 0 lvl=127 and the previous row's last lvl=0 → only y[8:1]==127 drawn; no span from 0.

Source files
------------

// File: rtl/wave_display_pkg.sv
// Shared constants and types for the waveform display stage: plot window
// geometry, FSM encoding, pipeline depth and per-stage pixel bundle.
package wave_display_pkg;

    localparam int X_START     = 256;
    localparam int X_END       = 767;
    localparam int PLOT_ROWS   = 512;
    localparam int PIPE_STAGES = 3;

    localparam logic [23:0] TRACE_RGB = 24'hFFFFFF;
    localparam logic [23:0] BG_RGB    = 24'h000000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } disp_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Raster position reduced to what the later stages actually need.
    typedef struct packed {
        logic       in_plot;
        logic       first_col;
        logic [7:0] sidx;
        logic [7:0] row;
    } pix_t;

endpackage

// File: rtl/wave_display_if.sv
// Raster-in / sample-RAM / pixel-out bundle for wave_display. The slave side
// is the display itself; the master side is the surrounding VGA/RAM fabric.
interface wave_display_if;

    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [8:0]  read_address;
    logic [7:0]  read_value;
    logic        valid_pixel;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        wave_display_idle;

    modport master (
        output x, y, valid, read_index, read_value,
        input  read_address, valid_pixel, r, g, b, wave_display_idle
    );

    modport slave (
        input  x, y, valid, read_index, read_value,
        output read_address, valid_pixel, r, g, b, wave_display_idle
    );

endinterface

// File: rtl/wave_display_span_check.sv
// Decides whether a plot row lies on the vertical segment joining the previous
// and current sample levels; with no previous level only the current row hits.
module wave_span_check (
    input  logic [7:0] prev_lvl,
    input  logic       prev_valid,
    input  logic [7:0] lvl,
    input  logic [7:0] row,
    output logic       draw
);

    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        lo   = (prev_lvl < lvl) ? prev_lvl : lvl;
        hi   = (prev_lvl < lvl) ? lvl : prev_lvl;
        draw = prev_valid ? (row >= lo && row <= hi) : (row == lvl);
    end

endmodule

// File: rtl/wave_display.sv
// Renders the captured sample buffer as a connected trace: raster position ->
// RAM address -> level compare -> registered colour, three cycles end to end.
module wave_display
    import wave_display_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    wave_display_if.slave bus
);

    disp_state_t state;
    logic        idle_q;
    logic        latched_index;
    logic [8:0]  addr_q;

    logic [PIPE_STAGES:0] vld_pipe;
    logic [PIPE_STAGES:1] vld_q;

    pix_t pix0, pix1, pix2;
    logic start, stop;

    logic [7:0] lvl, last_lvl, prev_lvl, last_sidx, eff_prev_lvl;
    logic       last_valid, prev_valid, eff_prev_valid, new_sample, draw;
    rgb_t       rgb_q;

    assign vld_pipe = {vld_q, bus.valid};

    assign start = bus.valid && bus.x == 11'd0 && bus.y == 10'd0;
    assign stop  = bus.valid && bus.y == 10'(PLOT_ROWS);

    // Drawing and address generation only happen inside an active frame, so
    // after reset nothing is rendered until the next frame start.
    always_comb begin
        pix0.in_plot   = bus.valid && state == ACTIVE &&
                         bus.x >= 11'(X_START) && bus.x <= 11'(X_END) &&
                         bus.y < 10'(PLOT_ROWS);
        pix0.first_col = bus.x == 11'(X_START);
        pix0.sidx      = 8'((bus.x - 11'(X_START)) >> 1);
        pix0.row       = bus.y[8:1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            idle_q        <= 1'b1;
            latched_index <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state         <= ACTIVE;
                    idle_q        <= 1'b0;
                    latched_index <= bus.read_index;
                end
                ACTIVE: if (stop) begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            vld_q  <= '0;
            pix1   <= '0;
            pix2   <= '0;
        end else begin
            vld_q <= vld_pipe[PIPE_STAGES-1:0];
            pix1  <= pix0;
            pix2  <= pix1;
            if (pix0.in_plot)
                addr_q <= {latched_index, pix0.sidx};
        end
    end

    // Stage 2: read_value belongs to pix2. The segment for a pixel spans from
    // the previous sample's level to this one; the first column has none.
    assign lvl        = 8'd255 - bus.read_value;
    assign new_sample = pix2.sidx != last_sidx;

    always_comb begin
        eff_prev_lvl   = prev_lvl;
        eff_prev_valid = prev_valid;
        if (pix2.first_col) begin
            eff_prev_valid = 1'b0;
        end else if (new_sample) begin
            eff_prev_lvl   = last_lvl;
            eff_prev_valid = last_valid;
        end
    end

    wave_span_check u_span (
        .prev_lvl   (eff_prev_lvl),
        .prev_valid (eff_prev_valid),
        .lvl        (lvl),
        .row        (pix2.row),
        .draw       (draw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_lvl   <= '0;
            prev_valid <= 1'b0;
            last_lvl   <= '0;
            last_valid <= 1'b0;
            last_sidx  <= '0;
            rgb_q      <= '0;
        end else begin
            if (pix2.in_plot && (pix2.first_col || new_sample)) begin
                prev_lvl   <= eff_prev_lvl;
                prev_valid <= eff_prev_valid;
                last_lvl   <= lvl;
                last_valid <= 1'b1;
                last_sidx  <= pix2.sidx;
            end
            if (!vld_pipe[PIPE_STAGES-1])
                rgb_q <= '0;
            else if (pix2.in_plot && draw)
                rgb_q <= TRACE_RGB;
            else
                rgb_q <= BG_RGB;
        end
    end

    assign bus.read_address      = addr_q;
    assign bus.valid_pixel       = vld_pipe[PIPE_STAGES];
    assign bus.r                 = rgb_q.r;
    assign bus.g                 = rgb_q.g;
    assign bus.b                 = rgb_q.b;
    assign bus.wave_display_idle = idle_q;

endmodule
